// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
//   Bundles the byte-write side and the transmitter-handshake side of the
//   UART byte feeder.
//
//   Handshake semantics:
//     - wr_en/wr_data is a one-cycle write strobe with no backpressure.
//       A strobe that arrives while fifo_full=1 and no pop happens in the
//       same cycle is dropped and reported on overflow.
//     - tx_int/send_complete is the transmitter trigger handshake. The
//       feeder raises tx_int only while send_complete=1 (transmitter idle).
//       The transmitter starts on the tx_int falling edge and drops
//       send_complete while it is sending. It raises send_complete again
//       when it is done. tx_data is held from the pop until that rise.
//
//   Modports:
//     master : write/transmitter environment (drives wr_en, wr_data, send_complete)
//     slave  : the feeder itself
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic [7:0]            tx_data;
  logic                  tx_int;
  logic                  send_complete;
  logic                  busy;
  logic                  overflow;
  logic                  timeout_err;

  modport master (
    output wr_en, wr_data, send_complete,
    input  fifo_full, fifo_empty, fifo_count, tx_data, tx_int,
           busy, overflow, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, send_complete,
    output fifo_full, fifo_empty, fifo_count, tx_data, tx_int,
           busy, overflow, timeout_err
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus trigger sequencer in front of the UART transmitter.
//   Bytes are queued from the frame builder. Each byte is popped onto
//   tx_data while the transmitter reports idle. tx_int is held high for
//   HOLD_CYCLES and then dropped to start the transmitter. The feeder
//   then waits for send_complete to fall and rise again before it pops
//   the next byte.
//
//   Ports:
//     clk         : system clock
//     rst_n       : asynchronous active-low reset
//     bus         : uart_tx_feeder_if.slave (write strobe, FIFO flags,
//                   tx_data/tx_int, send_complete, busy, overflow, timeout_err)
//     dbg_state_o : current sequencer state (0 IDLE, 1 LOAD, 2 FALL_WAIT, 3 DONE_WAIT)
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_feeder_if.slave     bus,
  output logic [1:0]          dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int HW    = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)      : 1;
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    FALL_WAIT = 2'd2,
    DONE_WAIT = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, overflow_q;

  // Sequencer
  state_e                state_q;
  logic                  tx_int_q;
  logic [7:0]            tx_data_q;
  logic [HW-1:0]         hold_q;
  logic [TW-1:0]         to_q;
  logic [TW-1:0]         to_inc;
  logic                  timeout_q;

  logic                  pop;
  logic                  push;

  // A pop only happens from IDLE while the transmitter is idle. This also
  // covers a transmitter that is still busy when reset is released.
  assign pop  = (state_q == IDLE) && !empty_q && bus.send_complete;
  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign push = bus.wr_en && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Storage has no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= bus.wr_en && !push;
    end
  end

  assign to_inc = to_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_int_q  <= 1'b0;
      tx_data_q <= 8'h00;
      hold_q    <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_int_q <= 1'b0;
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_int_q  <= 1'b1;
            // Counts down to zero; tx_int drops on the edge after it reaches zero.
            hold_q    <= HW'(HOLD_CYCLES - 1);
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (hold_q == '0) begin
            tx_int_q <= 1'b0;
            to_q     <= '0;
            state_q  <= FALL_WAIT;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        FALL_WAIT: begin
          to_q <= to_inc;
          if (!bus.send_complete) begin
            state_q <= DONE_WAIT;
          end else if (to_inc == TW'(BUSY_TIMEOUT)) begin
            // The transmitter never acknowledged: the byte is dropped, not retried.
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        DONE_WAIT: begin
          if (bus.send_complete) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_full   = full_q;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_count  = count_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_int      = tx_int_q;
  assign bus.busy        = (state_q != IDLE) || !empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  logic       sc_force_en;
  logic       sc_force_val;
  logic       sc_model;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ovf_cnt = 0;
  int to_cnt = 0;
  int rst_epoch = 0;

  logic [7:0] exp_q[$];

  uart_tx_feeder_if #(.DEPTH_LOG2(4)) bus ();

  uart_tx_feeder #(
    .DEPTH_LOG2  (4),
    .HOLD_CYCLES (2),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  assign bus.send_complete = sc_force_en ? sc_force_val : sc_model;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit expect_tx);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (expect_tx) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy || !bus.send_complete) && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", 32'(n < budget), 32'd1);
  endtask

  // ---------------- transmitter model + scoreboard ----------------
  // Drops send_complete 3 cycles after the tx_int fall, holds it low for
  // 20 cycles (the frame time), then raises it again.
  initial begin
    logic [7:0] got;
    int ep;
    sc_model = 1'b1;
    forever begin
      @(negedge bus.tx_int);
      if (!sc_force_en && rst_n) begin
        ep = rst_epoch;
        repeat (3) @(posedge clk);
        #1;
        got = bus.tx_data;
        if (ep == rst_epoch) begin
          if (exp_q.size() == 0) check("rx_extra", 32'd1, 32'd0);
          else check("rx_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
          rx_cnt++;
        end
        sc_model = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        if (ep == rst_epoch) check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, got});
        sc_model = 1'b1;
      end
    end
  end

  // A new trigger must never start while the transmitter is busy.
  always @(posedge bus.tx_int) begin
    if (rst_n) check("pop_while_busy", {31'd0, bus.send_complete}, 32'd1);
  end

  always @(negedge clk) begin
    if (bus.overflow)    ovf_cnt++;
    if (bus.timeout_err) to_cnt++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int k;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    sc_force_en  = 1'b0;
    sc_force_val = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_int",   {31'd0, bus.tx_int},      32'd0);
    check("rst_tx_data",  {24'd0, bus.tx_data},     32'd0);
    check("rst_count",    {27'd0, bus.fifo_count},  32'd0);
    check("rst_empty",    {31'd0, bus.fifo_empty},  32'd1);
    check("rst_full",     {31'd0, bus.fifo_full},   32'd0);
    check("rst_busy",     {31'd0, bus.busy},        32'd0);
    check("rst_overflow", {31'd0, bus.overflow},    32'd0);
    check("rst_timeout",  {31'd0, bus.timeout_err}, 32'd0);
    check("rst_state",    {30'd0, dbg_state},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // ---- single byte: latency and tx_int width ----
    wr_byte(8'hA5, 1'b1);
    check("sb_empty_after_wr", {31'd0, bus.fifo_empty}, 32'd0);
    check("sb_count_after_wr", {27'd0, bus.fifo_count}, 32'd1);
    check("sb_tx_int_pre",     {31'd0, bus.tx_int},     32'd0);
    step();
    check("sb_tx_int_rise",    {31'd0, bus.tx_int},     32'd1);
    check("sb_tx_data",        {24'd0, bus.tx_data},    32'hA5);
    check("sb_empty_after_pop",{31'd0, bus.fifo_empty}, 32'd1);
    check("sb_busy",           {31'd0, bus.busy},       32'd1);
    step();
    check("sb_tx_int_hold",    {31'd0, bus.tx_int},     32'd1);
    step();
    check("sb_tx_int_fall",    {31'd0, bus.tx_int},     32'd0);
    check("sb_tx_data_fall",   {24'd0, bus.tx_data},    32'hA5);
    wait_idle(200);
    check("sb_rx_cnt",         32'(rx_cnt),             32'd1);

    // ---- burst to full with transmitter busy, then overflow ----
    @(negedge clk);
    sc_force_en  = 1'b1;
    sc_force_val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    check("burst_full",   {31'd0, bus.fifo_full},  32'd1);
    check("burst_count",  {27'd0, bus.fifo_count}, 32'd16);
    check("burst_no_ovf", {31'd0, bus.overflow},   32'd0);
    check("burst_no_tx",  {31'd0, bus.tx_int},     32'd0);
    bus.wr_data = 8'hFF;
    @(negedge clk);
    check("ovf_pulse",    {31'd0, bus.overflow},   32'd1);
    check("ovf_count",    {27'd0, bus.fifo_count}, 32'd16);
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("ovf_one_cycle",{31'd0, bus.overflow},   32'd0);

    // ---- pop and write coincide at full ----
    @(negedge clk);
    sc_force_en = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3C;
    exp_q.push_back(8'h3C);
    step();
    bus.wr_en = 1'b0;
    check("pw_count",   {27'd0, bus.fifo_count}, 32'd16);
    check("pw_full",    {31'd0, bus.fifo_full},  32'd1);
    check("pw_no_ovf",  {31'd0, bus.overflow},   32'd0);
    check("pw_tx_int",  {31'd0, bus.tx_int},     32'd1);
    check("pw_tx_data", {24'd0, bus.tx_data},    32'h00);
    wait_idle(3000);
    check("burst_rx_cnt", 32'(rx_cnt), 32'd18);
    check("burst_drain",  32'(exp_q.size()), 32'd0);

    // ---- handshake timeout ----
    @(negedge clk);
    sc_force_en  = 1'b1;
    sc_force_val = 1'b1;
    wr_byte(8'h11, 1'b0);
    n = 0;
    while (!bus.tx_int && n < 10) begin step(); n++; end
    while (bus.tx_int && n < 20) begin step(); n++; end
    check("to_fall_seen", {31'd0, bus.tx_int}, 32'd0);
    k = 0;
    while (!bus.timeout_err && k < 20) begin step(); k++; end
    check("to_latency",  32'(k),                     32'd8);
    check("to_state",    {30'd0, dbg_state},         32'd0);
    check("to_busy",     {31'd0, bus.busy},          32'd0);
    step();
    check("to_one_cycle",{31'd0, bus.timeout_err},   32'd0);
    @(negedge clk);
    sc_force_en = 1'b0;
    wr_byte(8'h22, 1'b1);
    wait_idle(200);
    check("to_next_rx_cnt", 32'(rx_cnt), 32'd19);

    // ---- reset during DONE_WAIT with 5 bytes queued ----
    for (int i = 0; i < 6; i++) wr_byte(8'h40 + 8'(i), 1'b1);
    n = 0;
    while (dbg_state != 2'd3 && n < 50) begin step(); n++; end
    check("rm_in_done_wait", {30'd0, dbg_state},      32'd3);
    check("rm_count5",       {27'd0, bus.fifo_count}, 32'd5);
    @(negedge clk);
    rst_epoch++;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rm_tx_data", {24'd0, bus.tx_data},    32'd0);
    check("rm_count",   {27'd0, bus.fifo_count}, 32'd0);
    check("rm_empty",   {31'd0, bus.fifo_empty}, 32'd1);
    check("rm_busy",    {31'd0, bus.busy},       32'd0);
    check("rm_state",   {30'd0, dbg_state},      32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.tx_int) k++;
    end
    check("rm_no_tx_after", 32'(k), 32'd0);
    check("rm_empty_after", {31'd0, bus.fifo_empty}, 32'd1);

    check("total_overflows", 32'(ovf_cnt), 32'd1);
    check("total_timeouts",  32'(to_cnt),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
